// File: rtl/bram_ctrl_pkg.sv
// Shared types and helpers for the capture BRAM sequencer.
package bram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Width of a modulo-depth counter; never below one bit.
    function automatic int unsigned ctr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/capture_addr_ctr.sv
// Modulo-DEPTH address counter with synchronous clear and wrap flag.
module capture_addr_ctr
    import bram_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW = ctr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] q,
    output logic          wrap
);

    // Wrap is flagged on the increment that leaves the last address.
    assign wrap = en & (q == AW'(DEPTH - 1));

    // Clear has priority over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= wrap ? '0 : q + AW'(1);
        end
    end

endmodule

// File: rtl/bram_capture_ctrl.sv
// Capture BRAM sequencer: armed trigger capture of DEPTH samples, then host readout.
module bram_capture_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 1,
    localparam int unsigned AW = ctr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic          trigger,
    input  logic          arm,
    input  logic          abort,
    input  logic          rd_req,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic          rd_last,
    output logic          busy,
    output logic          done
);

    state_t              state_q;
    state_t              state_d;
    logic                ctr_clr;
    logic                wr_wrap;
    logic                rd_wrap;
    logic [RD_LAT-1:0]   vld_pipe;
    logic [RD_LAT-1:0]   last_pipe;

    capture_addr_ctr #(.DEPTH(DEPTH)) u_wr_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (ctr_clr),
        .en   (wr_en),
        .q    (wr_addr),
        .wrap (wr_wrap)
    );

    capture_addr_ctr #(.DEPTH(DEPTH)) u_rd_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (ctr_clr),
        .en   (rd_en),
        .q    (rd_addr),
        .wrap (rd_wrap)
    );

    // BRAM strobes depend only on state and datapath/host inputs; never both at once.
    always_comb begin
        wr_en = 1'b0;
        rd_en = 1'b0;
        case (state_q)
            ST_ARMED:   wr_en = trigger & valid;
            ST_CAPTURE: wr_en = valid;
            ST_DONE:    rd_en = rd_req;
            default:    ;
        endcase
    end

    // Next-state and counter clear; abort overrides everything.
    always_comb begin
        state_d = state_q;
        ctr_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_ARMED;
                    ctr_clr = 1'b1;
                end
            end
            ST_ARMED: begin
                if (wr_en) begin
                    state_d = wr_wrap ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (wr_wrap) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (arm) begin
                    state_d = ST_ARMED;
                    ctr_clr = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            ctr_clr = 1'b1;
        end
    end

    // State register with registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
            done    <= (state_d == ST_DONE);
        end
    end

    // Read-valid/last delay line matching BRAM latency; drains through abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= rd_en;
            last_pipe[0] <= rd_wrap;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    assign rd_valid = vld_pipe[RD_LAT-1];
    assign rd_last  = last_pipe[RD_LAT-1];

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Self-checking bench for bram_capture_ctrl (DEPTH=8, RD_LAT=1).
module tb_bram_capture_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic          clk;
    logic          rst;
    logic          valid, trigger, arm, abort, rd_req;
    logic          wr_en, rd_en, rd_valid, rd_last, busy, done;
    logic [AW-1:0] wr_addr, rd_addr;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase 0 idle, 1 armed, 2 capturing, 3 holding a full buffer.
    int   m_phase = 0;
    int   m_wa    = 0;
    int   m_ra    = 0;
    logic m_rv    = 1'b0;
    logic m_rl    = 1'b0;

    bram_capture_ctrl #(.DEPTH(DEPTH), .RD_LAT(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .trigger  (trigger),
        .arm      (arm),
        .abort    (abort),
        .rd_req   (rd_req),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_last  (rd_last),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic e_wr, e_rd;
        e_wr = ((m_phase == 1) && trigger && valid) || ((m_phase == 2) && valid);
        e_rd = (m_phase == 3) && rd_req;
        chk("wr_en",    32'(wr_en),    32'(e_wr));
        chk("wr_addr",  32'(wr_addr),  32'(m_wa));
        chk("rd_en",    32'(rd_en),    32'(e_rd));
        chk("rd_addr",  32'(rd_addr),  32'(m_ra));
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("rd_last",  32'(rd_last),  32'(m_rl));
        chk("busy",     32'(busy),     32'((m_phase == 1) || (m_phase == 2)));
        chk("done",     32'(done),     32'(m_phase == 3));
        chk("excl",     32'(wr_en & rd_en), 32'(0));
    endtask

    task automatic model_step();
        logic e_rd;
        e_rd = (m_phase == 3) && rd_req;
        m_rv = e_rd;
        m_rl = e_rd && (m_ra == DEPTH - 1);
        if (abort) begin
            m_phase = 0; m_wa = 0; m_ra = 0;
        end else begin
            case (m_phase)
                0: if (arm) begin m_phase = 1; m_wa = 0; end
                1: if (trigger && valid) begin m_phase = 2; m_wa = 1; end
                2: if (valid) begin
                       if (m_wa == DEPTH - 1) begin m_wa = 0; m_phase = 3; end
                       else m_wa = m_wa + 1;
                   end
                default: begin
                    if (arm) begin m_phase = 1; m_wa = 0; m_ra = 0; end
                    else if (rd_req) m_ra = (m_ra + 1) % DEPTH;
                end
            endcase
        end
    endtask

    // One clock cycle: drive at negedge, check mid-cycle, advance model at posedge.
    task automatic cyc(input logic v, input logic t, input logic a, input logic ab, input logic rq);
        @(negedge clk);
        valid = v; trigger = t; arm = a; abort = ab; rd_req = rq;
        #1;
        check_all();
        @(posedge clk);
        model_step();
    endtask

    initial begin
        rst = 1'b0;
        valid = 1'b0; trigger = 1'b0; arm = 1'b0; abort = 1'b0; rd_req = 1'b0;
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Basic capture with valid every cycle.
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("done_after_basic", 32'(done), 32'(1));

        // Readout with wrap, then drain.
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Re-arm from the full buffer and capture with sparse valid.
        cyc(0, 0, 1, 0, 1);
        cyc(1, 1, 0, 0, 0);
        for (int i = 1; i < 40 && m_phase != 3; i++) cyc((i % 3) == 0, 1, 0, 0, 0);
        chk("done_after_sparse", 32'(m_phase), 32'(3));
        cyc(0, 0, 0, 0, 0);

        // Abort after four writes, then restart from address 0.
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("idle_after_abort", 32'({busy, done}), 32'(0));
        cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // arm with abort in IDLE stays idle; arm during capture is ignored.
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 1, 0, 0, 0);
        chk("idle_after_arm_abort", 32'(busy), 32'(0));
        cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 0, (i == 2), 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 1) == 1));
        end

        // Async reset mid-capture, then trigger without arm.
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        @(negedge clk);
        valid = 1'b1; trigger = 1'b1; arm = 1'b0; abort = 1'b0; rd_req = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("rst_wr_en",   32'(wr_en),   32'(0));
        chk("rst_wr_addr", 32'(wr_addr), 32'(0));
        chk("rst_busy",    32'(busy),    32'(0));
        chk("rst_flags",   32'({rd_en, rd_valid, rd_last, done}), 32'(0));
        m_phase = 0; m_wa = 0; m_ra = 0; m_rv = 1'b0; m_rl = 1'b0;
        valid = 1'b0; trigger = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
        chk("no_capture_without_arm", 32'(busy), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
